// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the R-type core.
// Optional SEQ_SINGLE_STEP_EN adds step_en: every writeback then re-halts.
module core_sequencer #(
  parameter int          N        = 32,
  parameter int          MAX_WAIT = 8,
  parameter logic [6:0]  R_OPCODE = 7'b0110011
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] inst_code,
  input  logic         write_en_in,
  output logic         rf_write_en,
  output logic         pc_en,
  input  logic         halt_req,
  input  logic         resume,
  output logic         halted,
  output logic         busy,
  output logic [1:0]   fault_cause,
`ifdef SEQ_SINGLE_STEP_EN
  output logic [31:0]  retired_count,
  input  logic         step_en
`else
  output logic [31:0]  retired_count
`endif
);

  // state     | meaning
  // IDLE      | first cycle after reset, checks halt_req
  // FETCH     | imem_req high, waiting for imem_ack
  // DECODE    | opcode legality check
  // EXECUTE   | ALU settle cycle
  // WRITEBACK | gated register write, PC advance, retire
  // HALT      | stopped; resume only if no fault recorded
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT
  } state_t;

  localparam int             WW        = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   inst_q, inst_d;
  logic [31:0]    retired_q, retired_d;
  logic [1:0]     fault_q, fault_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           stop_after_wb;

`ifdef SEQ_SINGLE_STEP_EN
  assign stop_after_wb = halt_req | step_en;
`else
  assign stop_after_wb = halt_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      retired_q <= '0;
      fault_q   <= 2'b00;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    retired_d   = retired_q;
    fault_d     = fault_q;
    wait_d      = wait_q;
    imem_req    = 1'b0;
    rf_write_en = 1'b0;
    pc_en       = 1'b0;
    halted      = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: state_d = halt_req ? HALT : FETCH;
      FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_ack) begin
          inst_d  = imem_rdata;
          wait_d  = '0;
          state_d = DECODE;
        end else if (wait_q == WAIT_LAST) begin
          // ack on the last allowed cycle is handled above, so it wins
          wait_d  = '0;
          fault_d = 2'b01;
          state_d = HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        busy = 1'b1;
        if (inst_q[6:0] != R_OPCODE) begin
          fault_d = 2'b10;
          state_d = HALT;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        busy    = 1'b1;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        busy        = 1'b1;
        rf_write_en = write_en_in;
        pc_en       = 1'b1;
        retired_d   = retired_q + 32'd1;
        state_d     = stop_after_wb ? HALT : FETCH;
      end
      HALT: begin
        halted = 1'b1;
        if (resume && fault_q == 2'b00) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_code     = inst_q;
  assign fault_cause   = fault_q;
  assign retired_count = retired_q;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the R-type core. It sequences fetch, decode, execute and writeback around the existing datapath and control unit. It handshakes with instruction memory, holds the instruction register, gates the register-file write enable to one cycle per instruction, and pulses PC advance. It also provides halt/resume, fault capture and a retired-instruction counter.

Parameters:
N, 32, instruction/data width
MAX_WAIT, 8, max FETCH cycles without imem_ack before timeout fault (>=1)
R_OPCODE, 7'b0110011, only legal opcode (inst_code[6:0])

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request, high throughout FETCH
imem_ack  in  1  instruction valid; sampled only while imem_req=1
imem_rdata  in  N  instruction word, captured on imem_ack
inst_code  out  N  instruction register, drives datapath/control_unit
write_en_in  in  1  write enable from control_unit
rf_write_en  out  1  gated register-file write enable
pc_en  out  1  one-cycle PC advance pulse
halt_req  in  1  level; request halt at instruction boundary
resume  in  1  pulse; leave HALT
halted  out  1  high in HALT
busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
fault_cause  out  2  00 none, 01 fetch timeout, 10 illegal opcode
retired_count  out  32  instructions completed, wraps 2^32-1 -> 0

Behaviour:
- Reset (reset=0, async): state IDLE; inst_code=0, retired_count=0, fault_cause=00, wait counter=0.
- Reset outputs: imem_req, rf_write_en, pc_en, halted and busy are all 0.
- Reset mid-instruction aborts immediately. No write or pc_en is issued afterwards.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT. All transitions happen on the rising clk edge.
- IDLE: go to HALT if halt_req=1, otherwise go to FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ack=1: capture imem_rdata into inst_code, clear the wait counter, go to DECODE.
  - Otherwise increment the wait counter. At the end of the MAX_WAIT-th cycle without ack: fault_cause=01, go to HALT.
  - An ack on the MAX_WAIT-th cycle wins over the timeout.
  - imem_ack outside FETCH is ignored.
- DECODE: if inst_code[6:0] != R_OPCODE, set fault_cause=10 and go to HALT, with no write and no pc_en. Otherwise go to EXECUTE.
- EXECUTE: one ALU settle cycle; no outputs asserted.
- WRITEBACK:
  - rf_write_en = write_en_in, combinational and valid this cycle only.
  - pc_en=1; retired_count += 1.
  - Next state: HALT if halt_req=1, otherwise FETCH.
- halt_req is checked only in IDLE and WRITEBACK. An in-flight instruction always completes.
- HALT:
  - halted=1.
  - resume=1 with fault_cause=00 goes to FETCH.
  - resume=1 with fault_cause!=00 is ignored; only reset exits a fault.
  - halt_req is ignored in HALT.
  - Simultaneous halt_req and resume in HALT: resume wins, then halt takes effect at the next WRITEBACK.
- Latency: 4 cycles per instruction when ack arrives in the first FETCH cycle (FETCH, DECODE, EXECUTE, WRITEBACK). Each extra ack wait cycle adds 1.
- inst_code holds its value outside FETCH captures, including in HALT.
- rf_write_en and pc_en are never high outside WRITEBACK.

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined: adds input step_en (1 bit). When step_en=1, WRITEBACK always goes to HALT. Each resume then executes exactly one instruction and re-halts.
- Undefined: no step_en port; behaviour is identical to step_en=0.

Test Plan:
1. Reset release with imem_ack=1 always and imem_rdata=0x002081B3 (add x3,x1,x2), write_en_in=1 -> first pc_en in the 5th cycle after release (IDLE+4); rf_write_en 1 cycle wide; retired_count=3 after 13 cycles.
2. MAX_WAIT=8, imem_ack held 0 -> imem_req high 8 cycles, then halted=1, fault_cause=01, busy=0; resume pulse ignored; reset clears fault_cause to 00.
3. Ack on the 8th FETCH cycle -> no fault; DECODE follows; instruction retires normally.
4. imem_rdata=0x00000013 (addi) -> HALT after DECODE, fault_cause=10, rf_write_en and pc_en never asserted, retired_count unchanged.
5. halt_req raised mid-FETCH -> current instruction retires (pc_en=1), then halted=1. Resume pulse -> FETCH on the next cycle, imem_req=1.
6. Assert reset during EXECUTE -> all outputs 0 asynchronously, before the next clk edge; no write occurs. With SEQ_SINGLE_STEP_EN and step_en=1, three resumes -> retired_count=3, halted=1 after each.
